// File: rtl/ysyx_23060203_mem_rd_arbiter.sv
// Two-requester AXI read arbiter: the IFU refill path and the LSU share one memory
// read port. Only one read transaction is in flight at a time, from AR acceptance
// through the final R beat. LSU has priority, but a streak counter bounds how many
// LSU grants in a row can pass a waiting IFU.
module ysyx_23060203_mem_rd_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int ID_W         = 4
) (
  input  logic              clock,
  input  logic              reset,

  // IFU read channels
  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic [ID_W-1:0]   ifu_arid,
  input  logic [7:0]        ifu_arlen,
  input  logic [2:0]        ifu_arsize,
  input  logic [1:0]        ifu_arburst,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic [1:0]        ifu_rresp,
  output logic              ifu_rlast,
  output logic [ID_W-1:0]   ifu_rid,

  // LSU read channels
  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic [ID_W-1:0]   lsu_arid,
  input  logic [7:0]        lsu_arlen,
  input  logic [2:0]        lsu_arsize,
  input  logic [1:0]        lsu_arburst,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [1:0]        lsu_rresp,
  output logic              lsu_rlast,
  output logic [ID_W-1:0]   lsu_rid,

  // Shared memory read port
  output logic              mem_arvalid,
  input  logic              mem_arready,
  output logic [ADDR_W-1:0] mem_araddr,
  output logic [ID_W-1:0]   mem_arid,
  output logic [7:0]        mem_arlen,
  output logic [2:0]        mem_arsize,
  output logic [1:0]        mem_arburst,
  input  logic              mem_rvalid,
  output logic              mem_rready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        mem_rresp,
  input  logic              mem_rlast,
  input  logic [ID_W-1:0]   mem_rid,

  // Write channels of the memory port are never used by this block
  output logic              mem_awvalid,
  output logic              mem_wvalid,
  output logic              mem_bready,

  // Current grant: 00 none, 01 IFU, 10 LSU
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IFU  = 2'b01;
  localparam logic [1:0] OWN_LSU  = 2'b10;
  localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);

  state_t     state;
  state_t     state_next;
  logic [1:0] owner_next;
  logic [3:0] streak;
  logic [3:0] streak_next;
  logic       sel_ifu;
  logic       sel_lsu;

  assign sel_ifu = (owner == OWN_IFU);
  assign sel_lsu = (owner == OWN_LSU);

  // State, grant and starvation counter registers; reset abandons any transaction
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      owner  <= OWN_NONE;
      streak <= 4'd0;
    end else begin
      state  <= state_next;
      owner  <= owner_next;
      streak <= streak_next;
    end
  end

  // Arbitration decision in IDLE and the handshakes that advance AR -> R -> IDLE
  always_comb begin
    state_next  = state;
    owner_next  = owner;
    streak_next = streak;
    case (state)
      ST_IDLE: begin
        owner_next = OWN_NONE;
        if (ifu_arvalid && lsu_arvalid) begin
          state_next = ST_AR;
          if (streak < LIMIT) begin
            owner_next  = OWN_LSU;
            streak_next = streak + 4'd1;
          end else begin
            owner_next  = OWN_IFU;
            streak_next = 4'd0;
          end
        end else if (ifu_arvalid) begin
          state_next  = ST_AR;
          owner_next  = OWN_IFU;
          streak_next = 4'd0;
        end else if (lsu_arvalid) begin
          state_next = ST_AR;
          owner_next = OWN_LSU;
        end
      end
      ST_AR: begin
        if (mem_arvalid && mem_arready) begin
          state_next = ST_R;
        end
      end
      ST_R: begin
        if (mem_rvalid && mem_rready && mem_rlast) begin
          state_next = ST_IDLE;
          owner_next = OWN_NONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        owner_next = OWN_NONE;
      end
    endcase
  end

  // AR channel: forward the owner's request combinationally while in ST_AR only
  always_comb begin
    mem_araddr  = sel_lsu ? lsu_araddr  : ifu_araddr;
    mem_arid    = sel_lsu ? lsu_arid    : ifu_arid;
    mem_arlen   = sel_lsu ? lsu_arlen   : ifu_arlen;
    mem_arsize  = sel_lsu ? lsu_arsize  : ifu_arsize;
    mem_arburst = sel_lsu ? lsu_arburst : ifu_arburst;
    mem_arvalid = (state == ST_AR) &&
                  ((sel_ifu && ifu_arvalid) || (sel_lsu && lsu_arvalid));
    ifu_arready = (state == ST_AR) && sel_ifu && mem_arready;
    lsu_arready = (state == ST_AR) && sel_lsu && mem_arready;
  end

  // R channel: payload fans out to both, but only the owner sees rvalid in ST_R
  always_comb begin
    mem_rready = (state == ST_R) &&
                 ((sel_ifu && ifu_rready) || (sel_lsu && lsu_rready));
    ifu_rvalid = (state == ST_R) && sel_ifu && mem_rvalid;
    lsu_rvalid = (state == ST_R) && sel_lsu && mem_rvalid;
    ifu_rdata  = mem_rdata;
    ifu_rresp  = mem_rresp;
    ifu_rlast  = mem_rlast;
    ifu_rid    = mem_rid;
    lsu_rdata  = mem_rdata;
    lsu_rresp  = mem_rresp;
    lsu_rlast  = mem_rlast;
    lsu_rid    = mem_rid;
  end

  assign mem_awvalid = 1'b0;
  assign mem_wvalid  = 1'b0;
  assign mem_bready  = 1'b0;

endmodule

// File: tb/tb_ysyx_23060203_mem_rd_arbiter.sv
// Scoreboard bench for the read arbiter: stimulus pushes the expected grants and
// beats, a negedge monitor pops and compares whenever the DUT presents them.
module tb_ysyx_23060203_mem_rd_arbiter;

  localparam int LIMIT = 4;
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IFU  = 2'b01;
  localparam logic [1:0] OWN_LSU  = 2'b10;

  logic        clock = 1'b0;
  logic        reset;

  logic        ifuArvalid, ifuArready, ifuRvalid, ifuRready, ifuRlast;
  logic [31:0] ifuAraddr, ifuRdata;
  logic [3:0]  ifuArid, ifuRid;
  logic [7:0]  ifuArlen;
  logic [2:0]  ifuArsize;
  logic [1:0]  ifuArburst, ifuRresp;

  logic        lsuArvalid, lsuArready, lsuRvalid, lsuRready, lsuRlast;
  logic [31:0] lsuAraddr, lsuRdata;
  logic [3:0]  lsuArid, lsuRid;
  logic [7:0]  lsuArlen;
  logic [2:0]  lsuArsize;
  logic [1:0]  lsuArburst, lsuRresp;

  logic        memArvalid, memArready, memRvalid, memRready, memRlast;
  logic [31:0] memAraddr, memRdata;
  logic [3:0]  memArid, memRid;
  logic [7:0]  memArlen;
  logic [2:0]  memArsize;
  logic [1:0]  memArburst, memRresp;
  logic        memAwvalid, memWvalid, memBready;
  logic [1:0]  owner;

  typedef struct {
    logic [1:0]  owner;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [3:0]  streak;
  } grant_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [3:0]  id;
  } beat_t;

  grant_t grantQ[$];
  beat_t  ifuQ[$];
  beat_t  lsuQ[$];

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int lastRlastCycle = -100;
  int gapArmCycle = 0;
  bit gapArm = 1'b0;
  logic prevArv = 1'b0;
  int memArStall = 0;
  bit memFlush = 1'b0;

  ysyx_23060203_mem_rd_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .ifu_arvalid(ifuArvalid), .ifu_arready(ifuArready), .ifu_araddr(ifuAraddr),
    .ifu_arid(ifuArid), .ifu_arlen(ifuArlen), .ifu_arsize(ifuArsize),
    .ifu_arburst(ifuArburst), .ifu_rvalid(ifuRvalid), .ifu_rready(ifuRready),
    .ifu_rdata(ifuRdata), .ifu_rresp(ifuRresp), .ifu_rlast(ifuRlast), .ifu_rid(ifuRid),
    .lsu_arvalid(lsuArvalid), .lsu_arready(lsuArready), .lsu_araddr(lsuAraddr),
    .lsu_arid(lsuArid), .lsu_arlen(lsuArlen), .lsu_arsize(lsuArsize),
    .lsu_arburst(lsuArburst), .lsu_rvalid(lsuRvalid), .lsu_rready(lsuRready),
    .lsu_rdata(lsuRdata), .lsu_rresp(lsuRresp), .lsu_rlast(lsuRlast), .lsu_rid(lsuRid),
    .mem_arvalid(memArvalid), .mem_arready(memArready), .mem_araddr(memAraddr),
    .mem_arid(memArid), .mem_arlen(memArlen), .mem_arsize(memArsize),
    .mem_arburst(memArburst), .mem_rvalid(memRvalid), .mem_rready(memRready),
    .mem_rdata(memRdata), .mem_rresp(memRresp), .mem_rlast(memRlast), .mem_rid(memRid),
    .mem_awvalid(memAwvalid), .mem_wvalid(memWvalid), .mem_bready(memBready),
    .owner(owner)
  );

  // 10 ns clock and a free-running cycle index used for turnaround checks
  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  function automatic logic [31:0] memData(input logic [31:0] addr, input int beat);
    return (addr + 32'(beat * 4)) ^ 32'hC0DE_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: timed out (cycle %0d)", name, cycle);
  endtask

  task automatic expectGrant(input logic [1:0] who, input logic [31:0] addr,
                             input logic [7:0] len, input logic [3:0] streak,
                             input logic [3:0] id, input int nBeats);
    grant_t g;
    beat_t  b;
    g.owner = who; g.addr = addr; g.len = len; g.streak = streak;
    grantQ.push_back(g);
    for (int i = 0; i < nBeats; i++) begin
      b.data = memData(addr, i);
      b.last = (i == int'(len));
      b.id   = id;
      if (who == OWN_IFU) ifuQ.push_back(b);
      else lsuQ.push_back(b);
    end
  endtask

  task automatic applyStimulus;
    @(posedge clock);
    #1;
  endtask

  // IFU read: hold AR until accepted, then take beats with an optional rready stall
  task automatic ifuRead(input logic [31:0] addr, input logic [7:0] len,
                         input int stallBeat, input int stallCycles,
                         input bit checkLatency, output int beats);
    int n;
    bit done;
    ifuAraddr = addr; ifuArid = 4'h1; ifuArlen = len; ifuArsize = 3'd2;
    ifuArburst = 2'b10; ifuArvalid = 1'b1; ifuRready = 1'b1;
    @(negedge clock);
    if (checkLatency) begin
      checkOutput("lat_idle_arvalid", memArvalid, 1'b0);
      @(negedge clock);
      checkOutput("lat_grant_arvalid", memArvalid, 1'b1);
      checkOutput("lat_grant_owner", owner, OWN_IFU);
    end
    n = 0;
    while (!ifuArready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!ifuArready) timeoutFail("ifu_ar_wait");
    @(posedge clock);
    #1 ifuArvalid = 1'b0;
    beats = 0; n = 0; done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clock);
      n++;
      if (ifuRvalid && ifuRready) begin
        beats++;
        if (ifuRlast) done = 1'b1;
        @(posedge clock);
        #1;
        if (!done && beats == stallBeat && stallCycles > 0) begin
          ifuRready = 1'b0;
          repeat (stallCycles) @(posedge clock);
          #1 ifuRready = 1'b1;
        end
      end
    end
    if (!done) timeoutFail("ifu_r_wait");
  endtask

  // LSU single-beat read; returns one cycle after the rlast handshake edge
  task automatic lsuRead(input logic [31:0] addr);
    int n;
    bit done;
    lsuAraddr = addr; lsuArid = 4'h2; lsuArlen = 8'd0; lsuArsize = 3'd2;
    lsuArburst = 2'b01; lsuArvalid = 1'b1; lsuRready = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!lsuArready && n < 200);
    if (!lsuArready) timeoutFail("lsu_ar_wait");
    @(posedge clock);
    #1 lsuArvalid = 1'b0;
    n = 0; done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clock);
      n++;
      if (lsuRvalid && lsuRready && lsuRlast) done = 1'b1;
    end
    if (!done) timeoutFail("lsu_r_wait");
    @(posedge clock);
    #1;
  endtask

  // Memory model: accepts AR after a programmable stall, then returns len+1 beats
  initial begin : memModel
    logic [31:0] addr;
    logic [7:0]  len;
    logic [3:0]  id;
    bit aborted;
    memArready = 1'b0; memRvalid = 1'b0; memRdata = '0; memRlast = 1'b0;
    memRid = '0; memRresp = 2'b00;
    forever begin
      @(negedge clock);
      if (memArvalid && !memFlush) begin
        repeat (memArStall) @(negedge clock);
        @(posedge clock);
        #1 memArready = 1'b1;
        @(negedge clock);
        addr = memAraddr; len = memArlen; id = memArid;
        @(posedge clock);
        #1 memArready = 1'b0;
        aborted = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
          memRvalid = 1'b1;
          memRdata  = memData(addr, b);
          memRlast  = (b == int'(len));
          memRid    = id;
          forever begin
            @(negedge clock);
            if (memFlush) begin
              aborted = 1'b1;
              break;
            end
            if (memRready) begin
              @(posedge clock);
              #1;
              break;
            end
          end
          if (aborted) break;
        end
        memRvalid = 1'b0;
        memRlast  = 1'b0;
      end
    end
  end

  // Monitor: compare forwarded AR, delivered beats, non-owner silence and turnaround
  always @(negedge clock) begin
    if (!reset) begin
      if (memArvalid) begin
        if (grantQ.size() == 0) begin
          timeoutFail("unexpected_ar");
        end else begin
          checkOutput("ar_owner", owner, grantQ[0].owner);
          checkOutput("ar_addr", memAraddr, grantQ[0].addr);
          if (memArready) begin
            checkOutput("ar_len", memArlen, grantQ[0].len);
            checkOutput("streak", dut.streak, grantQ[0].streak);
            void'(grantQ.pop_front());
          end
        end
        if (!prevArv && gapArm && lastRlastCycle > gapArmCycle)
          checkOutput("turnaround", 64'(cycle - lastRlastCycle), 64'd2);
      end
      prevArv = memArvalid;

      if (ifuRvalid && ifuRready) begin
        if (ifuQ.size() == 0) begin
          timeoutFail("unexpected_ifu_beat");
        end else begin
          checkOutput("ifu_rdata", ifuRdata, ifuQ[0].data);
          checkOutput("ifu_rlast", ifuRlast, ifuQ[0].last);
          checkOutput("ifu_rid", ifuRid, ifuQ[0].id);
          void'(ifuQ.pop_front());
        end
        if (ifuRlast) lastRlastCycle = cycle;
      end

      if (lsuRvalid && lsuRready) begin
        if (lsuQ.size() == 0) begin
          timeoutFail("unexpected_lsu_beat");
        end else begin
          checkOutput("lsu_rdata", lsuRdata, lsuQ[0].data);
          checkOutput("lsu_rlast", lsuRlast, lsuQ[0].last);
          checkOutput("lsu_rid", lsuRid, lsuQ[0].id);
          void'(lsuQ.pop_front());
        end
        if (lsuRlast) lastRlastCycle = cycle;
      end

      if (owner == OWN_IFU)
        checkOutput("lsu_quiet", {lsuArready, lsuRvalid}, 2'b00);
      else if (owner == OWN_LSU)
        checkOutput("ifu_quiet", {ifuArready, ifuRvalid}, 2'b00);
      else
        checkOutput("idle_quiet", {ifuArready, ifuRvalid, lsuArready, lsuRvalid,
                                   memArvalid, memRready}, 6'b0);
      checkOutput("write_quiet", {memAwvalid, memWvalid, memBready}, 3'b0);
    end
  end

  // Watchdog so the bench always terminates
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios
  initial begin
    int beats;
    int n;
    reset = 1'b1;
    ifuArvalid = 1'b0; ifuAraddr = '0; ifuArid = '0; ifuArlen = '0; ifuArsize = '0;
    ifuArburst = '0; ifuRready = 1'b0;
    lsuArvalid = 1'b0; lsuAraddr = '0; lsuArid = '0; lsuArlen = '0; lsuArsize = '0;
    lsuArburst = '0; lsuRready = 1'b0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_owner", owner, OWN_NONE);
    checkOutput("reset_streak", dut.streak, 4'd0);
    checkOutput("reset_handshakes", {memArvalid, memRready, ifuArready, ifuRvalid,
                                     lsuArready, lsuRvalid}, 6'b0);
    applyStimulus;
    reset = 1'b0;

    $display("[TB] lone IFU burst");
    applyStimulus;
    expectGrant(OWN_IFU, 32'h8000_0010, 8'd3, 4'd0, 4'h1, 4);
    ifuRead(32'h8000_0010, 8'd3, 0, 0, 1'b1, beats);
    checkOutput("lone_ifu_beats", beats, 4);
    @(negedge clock);
    checkOutput("lone_owner_release", owner, OWN_NONE);

    $display("[TB] simultaneous request");
    applyStimulus;
    expectGrant(OWN_LSU, 32'h0000_1000, 8'd0, 4'd1, 4'h2, 1);
    expectGrant(OWN_IFU, 32'h8000_0040, 8'd3, 4'd0, 4'h1, 4);
    gapArmCycle = cycle; gapArm = 1'b1;
    fork
      ifuRead(32'h8000_0040, 8'd3, 0, 0, 1'b0, beats);
      lsuRead(32'h0000_1000);
    join
    gapArm = 1'b0;
    checkOutput("simul_ifu_beats", beats, 4);

    $display("[TB] starvation limit");
    applyStimulus;
    expectGrant(OWN_LSU, 32'h0000_2000, 8'd0, 4'd1, 4'h2, 1);
    expectGrant(OWN_LSU, 32'h0000_2004, 8'd0, 4'd2, 4'h2, 1);
    expectGrant(OWN_LSU, 32'h0000_2008, 8'd0, 4'd3, 4'h2, 1);
    expectGrant(OWN_LSU, 32'h0000_200C, 8'd0, 4'd4, 4'h2, 1);
    expectGrant(OWN_IFU, 32'h8000_0080, 8'd3, 4'd0, 4'h1, 4);
    expectGrant(OWN_LSU, 32'h0000_2010, 8'd0, 4'd0, 4'h2, 1);
    gapArmCycle = cycle; gapArm = 1'b1;
    fork
      ifuRead(32'h8000_0080, 8'd3, 0, 0, 1'b0, beats);
      begin
        for (int i = 0; i < 5; i++) lsuRead(32'h0000_2000 + 32'(i * 4));
      end
    join
    gapArm = 1'b0;
    checkOutput("starve_ifu_beats", beats, 4);

    $display("[TB] backpressure");
    applyStimulus;
    memArStall = 4;
    expectGrant(OWN_IFU, 32'h8000_00C0, 8'd3, 4'd0, 4'h1, 4);
    expectGrant(OWN_LSU, 32'h0000_3000, 8'd0, 4'd0, 4'h2, 1);
    fork
      ifuRead(32'h8000_00C0, 8'd3, 2, 3, 1'b0, beats);
      begin
        repeat (2) @(posedge clock);
        #1 lsuRead(32'h0000_3000);
      end
    join
    memArStall = 0;
    checkOutput("bp_ifu_beats", beats, 4);

    $display("[TB] asynchronous reset mid-burst");
    applyStimulus;
    expectGrant(OWN_IFU, 32'h8000_0100, 8'd3, 4'd0, 4'h1, 2);
    ifuAraddr = 32'h8000_0100; ifuArid = 4'h1; ifuArlen = 8'd3; ifuArsize = 3'd2;
    ifuArburst = 2'b10; ifuArvalid = 1'b1; ifuRready = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!ifuArready && n < 200);
    if (!ifuArready) timeoutFail("rst_ar_wait");
    @(posedge clock);
    #1 ifuArvalid = 1'b0;
    beats = 0; n = 0;
    while (beats < 2 && n < 200) begin
      @(negedge clock);
      n++;
      if (ifuRvalid && ifuRready) beats++;
    end
    if (beats < 2) timeoutFail("rst_beat_wait");
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    checkOutput("rst_async_owner", owner, OWN_NONE);
    checkOutput("rst_async_mem_rready", memRready, 1'b0);
    checkOutput("rst_async_ifu_rvalid", ifuRvalid, 1'b0);
    memFlush = 1'b1;
    ifuRready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    memFlush = 1'b0;
    @(negedge clock);
    checkOutput("post_rst_streak", dut.streak, 4'd0);
    applyStimulus;
    expectGrant(OWN_LSU, 32'h0000_4000, 8'd0, 4'd0, 4'h2, 1);
    lsuRead(32'h0000_4000);

    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("grant_queue_drained", grantQ.size(), 0);
    checkOutput("ifu_queue_drained", ifuQ.size(), 0);
    checkOutput("lsu_queue_drained", lsuQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_23060203_mem_rd_arbiter.md
# ysyx_23060203_mem_rd_arbiter

Two-requester AXI read-channel arbiter sharing the single memory read port between the instruction cache refill path (IFU) and the load/store unit (LSU). It owns one outstanding read transaction at a time, from AR acceptance through the final R beat. It grants by fixed priority, with a starvation limit so IFU refills cannot be locked out by a stream of loads. It sits between the ICache/LSU `axi_if` read ports and the core's outbound memory read interface.

## Interface
- `STARVE_LIMIT`, default 4: maximum consecutive LSU grants allowed while IFU is waiting. Range 1..15.
- `clock`  in  1  core clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ifu_r`  `axi_if.in`  —  read channels (AR, R) from the ICache; write channels unused.
- `lsu_r`  `axi_if.in`  —  read channels (AR, R) from the LSU; write channels unused.
- `mem_r`  `axi_if.out`  —  shared read channels toward memory.
- `owner`  out  2  current grant: 2'b00 none, 2'b01 IFU, 2'b10 LSU.

## Operation
- States: ST_IDLE, ST_AR, ST_R. Registers: `state`, `owner`, and a 4-bit `streak` counter.
- **ST_IDLE**
  - No requester's `arvalid`: stay in ST_IDLE, `owner` = 00.
  - Otherwise select a winner, latch it into `owner`, and go to ST_AR.
  - Selection rule:
    - Only one requester valid: that requester wins.
    - Both valid and `streak` < STARVE_LIMIT: LSU wins, `streak` += 1.
    - Both valid and `streak` == STARVE_LIMIT: IFU wins.
    - Whenever IFU is granted, `streak` is cleared to 0.
    - An LSU grant with IFU not requesting leaves `streak` unchanged.
- **ST_AR**
  - `mem_r.arvalid`/`araddr`/`arid`/`arlen`/`arsize`/`arburst` are driven combinationally from the owner's AR signals.
  - Owner's `arready` = `mem_r.arready`; the non-owner's `arready` = 0.
  - On the AR handshake, go to ST_R.
- **ST_R**
  - `mem_r.rready` = owner's `rready`.
  - Owner's `rvalid`/`rdata`/`rresp`/`rlast`/`rid` are driven from `mem_r`; the non-owner's `rvalid` = 0.
  - On a handshake with `rlast` = 1, go to ST_IDLE and set `owner` = 00.
- Outside the matching state, `mem_r.arvalid` = 0 and `mem_r.rready` = 0.
- Both requesters' `arready` and `rvalid` are 0 in ST_IDLE.
- Requesters obey AXI: `arvalid` is held with stable payload until `arready`. The arbiter relies on this, because the decision is registered one cycle before forwarding.
- Write channels of `mem_r`: `awvalid` = `wvalid` = 0, `bready` = 0.
- Burst length is whatever the owner issues (IFU wraps of 4 beats, LSU single beats). The arbiter counts no beats; `rlast` alone ends ownership.

## Timing
- Reset (asynchronous, immediate): `state` = ST_IDLE, `owner` = 00, `streak` = 0.
- While reset is asserted, all `arvalid`/`arready`/`rvalid`/`rready` outputs are 0.
- Reset mid-burst abandons the transaction. Draining memory is the memory side's responsibility.
- Grant latency: requester `arvalid` rises in cycle N while in ST_IDLE → `mem_r.arvalid` = 1 in cycle N+1.
- AR and R paths are combinational pass-through; the arbiter adds zero cycles per handshake.
- Turnaround: `rlast` handshake in cycle M → ST_IDLE in M+1 → the next request is forwarded in M+2 (one bubble cycle).
- A requester raising `arvalid` during another's ST_AR/ST_R waits until the next ST_IDLE. There is no preemption.
- `owner` changes only on clock edges: ST_IDLE→ST_AR and ST_R→ST_IDLE.

## Test plan
- **Lone IFU burst.**
  - Stimulus: IFU `araddr` = 0x8000_0010, `arlen` = 3; memory returns 4 beats.
  - Required: `mem_r.arvalid` the cycle after `arvalid`; IFU sees 4 `rvalid` beats with `rlast` on the 4th; `owner` 01→00.
- **Simultaneous request.**
  - Stimulus: IFU and LSU assert in the same cycle, `streak` = 0.
  - Required: LSU granted first and `streak` = 1; IFU granted right after the LSU `rlast`, with exactly one idle cycle between.
- **Starvation limit.**
  - Stimulus: STARVE_LIMIT = 4; LSU issues back-to-back single reads while IFU holds `arvalid`.
  - Required: exactly 4 LSU grants, then IFU granted and `streak` = 0.
- **Backpressure.**
  - Stimulus: `mem_r.arready` low for 5 cycles, then the owner holds `rready` low for 3 cycles mid-burst.
  - Required: AR payload held stable throughout; non-owner `arready`/`rvalid` stay 0; no beat lost or duplicated.
- **Asynchronous reset mid-burst.**
  - Stimulus: assert `reset` between clock edges during beat 2 of an IFU burst.
  - Required: `owner` = 00, `mem_r.rready` = 0, and IFU `rvalid` = 0 immediately, before the next edge; a fresh LSU request after reset is granted normally.
